// File: rtl/main_mem_if.sv
// Bus between the cache interconnect and main_mem: request (valid/ready, we, addr, wdata)
// and read-beat response (valid, data) plus the sticky address-error flag.
interface main_mem_if #(
    parameter int unsigned dma_data_width_p = 4
) ();
    localparam int unsigned DATA_W = 32 * dma_data_width_p;

    logic              valid_i;
    logic              ready_o;
    logic              we_i;
    logic [31:0]       addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              error_o;

    modport master (
        output valid_i, we_i, addr_i, wdata_i,
        input  ready_o, valid_o, data_o, error_o
    );

    modport slave (
        input  valid_i, we_i, addr_i, wdata_i,
        output ready_o, valid_o, data_o, error_o
    );
endinterface

// File: rtl/main_mem.sv
// Behavioural main memory behind the cache bus. One request outstanding, fixed access
// latency with a one-cycle fast path for consecutive beats of the same block, same direction.
// Optional feature: define MAIN_MEM_ADDR_CHECK_EN to flag out-of-range or misaligned
// accesses on a sticky error_o (such writes are dropped, such reads return zero).
module main_mem #(
    parameter int unsigned block_width_p     = 16,
    parameter int unsigned dma_data_width_p  = 4,
    parameter int unsigned mem_depth_words_p = 4096,
    parameter int unsigned latency_p         = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    main_mem_if.slave  bus
);
    localparam int unsigned DATA_W    = 32 * dma_data_width_p;
    localparam int unsigned BEAT_SH   = $clog2(4 * dma_data_width_p);
    localparam int unsigned BLK_SH    = $clog2(4 * block_width_p);
    localparam int unsigned BLK_W     = 32 - BLK_SH;
    localparam int unsigned BPB       = block_width_p / dma_data_width_p;
    localparam int unsigned IDX_W     = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int unsigned MEM_BEATS = mem_depth_words_p / dma_data_width_p;
    localparam int unsigned MA_W      = (MEM_BEATS > 1) ? $clog2(MEM_BEATS) : 1;
    localparam int unsigned CNT_W     = $clog2(latency_p + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [DATA_W-1:0] mem_q [MEM_BEATS];

    logic [0:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              ready_q,   ready_d;
    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              error_q,   error_d;
    logic              open_q,    open_d;
    logic [BLK_W-1:0]  blk_q,     blk_d;
    logic              we_prev_q, we_prev_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_bad_q,  rd_bad_d;
    logic [MA_W-1:0]   rd_ma_q,   rd_ma_d;

    logic              accept_c;
    logic [BLK_W-1:0]  blk_c;
    logic [IDX_W-1:0]  idx_c;
    logic [MA_W-1:0]   ma_c;
    logic              fast_c;
    logic [CNT_W-1:0]  lat_c;
    logic              bad_c;
    logic              mem_we_c;

    // Request decode: accept, block/beat position, latency selection and address check
    always_comb begin
        accept_c = bus.valid_i & (state_q == S_IDLE) & ~reset_i;
        blk_c    = BLK_W'(bus.addr_i >> BLK_SH);
        idx_c    = IDX_W'((bus.addr_i >> BEAT_SH) & 32'(BPB - 1));
        ma_c     = MA_W'(bus.addr_i >> BEAT_SH);
        fast_c   = open_q & (blk_c == blk_q) & (bus.we_i == we_prev_q)
                 & (idx_c == IDX_W'(idx_q + 1'b1));
        lat_c    = fast_c ? CNT_W'(1) : CNT_W'(latency_p);
`ifdef MAIN_MEM_ADDR_CHECK_EN
        bad_c    = ((bus.addr_i >> 2) >= 32'(mem_depth_words_p))
                 | ((bus.addr_i & 32'(4 * dma_data_width_p - 1)) != 32'd0);
`else
        bad_c    = 1'b0;
`endif
    end

    // Next-state: IDLE accepts and loads the down-counter, BUSY counts down to 1
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        error_d   = error_q;
        open_d    = open_q;
        blk_d     = blk_q;
        we_prev_d = we_prev_q;
        idx_d     = idx_q;
        rd_pend_d = rd_pend_q;
        rd_bad_d  = rd_bad_q;
        rd_ma_d   = rd_ma_q;
        mem_we_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d   = S_BUSY;
                    cnt_d     = lat_c;
                    blk_d     = blk_c;
                    we_prev_d = bus.we_i;
                    rd_pend_d = ~bus.we_i;
                    rd_bad_d  = bad_c;
                    rd_ma_d   = ma_c;
                    error_d   = error_q | bad_c;
                    mem_we_c  = bus.we_i & ~bad_c;
                    // Last beat of a block closes it; anything else keeps it open
                    if (idx_c == IDX_W'(BPB - 1)) begin
                        open_d = 1'b0;
                        idx_d  = '0;
                    end else begin
                        open_d = 1'b1;
                        idx_d  = idx_c;
                    end
                    // Fast-path read responds in the very next cycle
                    if (~bus.we_i && (lat_c == CNT_W'(1))) begin
                        valid_d = 1'b1;
                        data_d  = bad_c ? '0 : mem_q[ma_c];
                    end
                end
            end
            default: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // Response lands in the last busy cycle
                if (rd_pend_q && (cnt_q == CNT_W'(2))) begin
                    valid_d = 1'b1;
                    data_d  = rd_bad_q ? '0 : mem_q[rd_ma_q];
                end
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            error_q   <= 1'b0;
            open_q    <= 1'b0;
            blk_q     <= '0;
            we_prev_q <= 1'b0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_bad_q  <= 1'b0;
            rd_ma_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            error_q   <= error_d;
            open_q    <= open_d;
            blk_q     <= blk_d;
            we_prev_q <= we_prev_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            rd_bad_q  <= rd_bad_d;
            rd_ma_q   <= rd_ma_d;
        end
    end

    // Storage: write committed at the accept edge, never cleared by reset
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_q[ma_c] <= bus.wdata_i;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.error_o = error_q;

endmodule
